// File: rtl/mul8_pkg.sv
// Shared definitions for the sequential 8x8 multiplier: FSM encoding and widths.
package mul8_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam int ITER_DEFAULT = 8;
    localparam int PROD_W       = 16;

endpackage

// File: rtl/fulladd8.sv
// 8-bit ripple-carry adder: a chain of single-bit full adders.
module fulladd8 (
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       cin,
    output logic [7:0] sum,
    output logic       cout
);

    logic [8:0] carry;

    assign carry[0] = cin;

    for (genvar i = 0; i < 8; i++) begin : g_bit
        assign sum[i]     = a[i] ^ b[i] ^ carry[i];
        assign carry[i+1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
    end

    assign cout = carry[8];

endmodule

// File: rtl/mul8_seq.sv
// Multi-cycle 8x8 unsigned shift-and-add multiplier with valid/ready on both sides.
// Optional early termination on exhausted multiplier bits: define MUL8_EARLY_TERM_EN.
module mul8_seq
    import mul8_pkg::*;
#(
    parameter int ITER  = ITER_DEFAULT,
    parameter int CNT_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [7:0]        mcand,
    input  logic [7:0]        mplier,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [PROD_W-1:0] product,
    output logic              busy
);

    state_e             state_q, state_d;
    logic [7:0]         acc_q, acc_d;
    logic [7:0]         mq_q, mq_d;
    logic [7:0]         mc_q, mc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               out_valid_q, out_valid_d;
    logic               in_ready_q, in_ready_d;
    logic               busy_q, busy_d;
    logic [PROD_W-1:0]  product_q, product_d;
    logic [PROD_W-1:0]  step;
    logic [7:0]         add_sum;
    logic               add_cout;
`ifdef MUL8_EARLY_TERM_EN
    logic [7:0]         mp_q, mp_d;
`endif

    fulladd8 u_add (
        .a    (acc_q),
        .b    (mc_q),
        .cin  (1'b0),
        .sum  (add_sum),
        .cout (add_cout)
    );

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        mq_d        = mq_q;
        mc_d        = mc_q;
        cnt_d       = cnt_q;
        out_valid_d = 1'b0;
        step        = {acc_q, mq_q};
`ifdef MUL8_EARLY_TERM_EN
        mp_d        = mp_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (in_valid && in_ready_q) begin
                    mc_d    = mcand;
                    mq_d    = mplier;
                    acc_d   = '0;
                    cnt_d   = '0;
`ifdef MUL8_EARLY_TERM_EN
                    mp_d    = mplier;
`endif
                    state_d = ST_CALC;
                end
            end
            ST_CALC: begin
                // The adder carry becomes the new MSB, so the shift never loses a bit.
                step  = mq_q[0] ? {add_cout, add_sum, mq_q[7:1]}
                                : {1'b0, acc_q, mq_q[7:1]};
                cnt_d = cnt_q + 1'b1;
`ifdef MUL8_EARLY_TERM_EN
                mp_d  = mp_q >> 1;
                if (mp_q == '0) begin
                    step    = {acc_q, mq_q} >> (CNT_W'(ITER) - cnt_q);
                    state_d = ST_DONE;
                end else if (mp_d == '0 || cnt_q == CNT_W'(ITER - 1)) begin
                    // Remaining iterations would only shift zeros in; do them at once.
                    step    = step >> (CNT_W'(ITER - 1) - cnt_q);
                    state_d = ST_DONE;
                end
`else
                if (cnt_q == CNT_W'(ITER - 1)) begin
                    state_d = ST_DONE;
                end
`endif
                acc_d = step[15:8];
                mq_d  = step[7:0];
            end
            ST_DONE: begin
                if (out_valid_q && out_ready) begin
                    state_d = ST_IDLE;
                end else begin
                    out_valid_d = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        product_d  = (state_d == ST_DONE) ? {acc_d, mq_d} : '0;
        busy_d     = (state_d != ST_IDLE);
        in_ready_d = (state_d == ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            acc_q       <= '0;
            mq_q        <= '0;
            mc_q        <= '0;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b0;
            busy_q      <= 1'b0;
            product_q   <= '0;
`ifdef MUL8_EARLY_TERM_EN
            mp_q        <= '0;
`endif
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            mq_q        <= mq_d;
            mc_q        <= mc_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
            busy_q      <= busy_d;
            product_q   <= product_d;
`ifdef MUL8_EARLY_TERM_EN
            mp_q        <= mp_d;
`endif
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign product   = product_q;

endmodule

// File: tb/tb_mul8_seq.sv
// Directed and random checks of mul8_seq: latency, handshake, back-pressure, async reset.
module tb_mul8_seq;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  mcand;
    logic [7:0]  mplier;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] product;
    logic        busy;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic [7:0]  a;
        logic [7:0]  b;
        logic [15:0] p;
    } vec_t;

    vec_t vecs[11];

    mul8_seq dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .mcand     (mcand),
        .mplier    (mplier),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .product   (product),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic int exp_lat(input logic [7:0] m);
        int r;
        r = 9;
`ifdef MUL8_EARLY_TERM_EN
        r = 2;
        for (int i = 0; i < 8; i++) begin
            if (m[i]) r = i + 2;
        end
`endif
        return r;
    endfunction

    // Called at a negedge; returns at a negedge with the product consumed.
    task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic [15:0] exp,
                          input string name);
        int lat;
        int wt;
        wt = 0;
        while (!in_ready && wt < 30) begin
            @(negedge clk);
            wt++;
        end
        check({name, " in_ready before accept"}, 32'(in_ready), 32'd1);
        mcand     = a;
        mplier    = b;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 30) begin
            @(negedge clk);
            lat++;
        end
        check({name, " latency"}, 32'(lat), 32'(exp_lat(b)));
        check({name, " product"}, 32'(product), 32'(exp));
        @(negedge clk);
        check({name, " out_valid single pulse"}, 32'(out_valid), 32'd0);
        check({name, " in_ready after accept"}, 32'(in_ready), 32'd1);
        check({name, " product cleared"}, 32'(product), 32'd0);
    endtask

    initial begin
        logic [7:0] ra;
        logic [7:0] rb;

        vecs[0]  = '{8'h0D, 8'h0B, 16'h008F};
        vecs[1]  = '{8'hFF, 8'hFF, 16'hFE01};
        vecs[2]  = '{8'h00, 8'hA5, 16'h0000};
        vecs[3]  = '{8'h80, 8'h02, 16'h0100};
        vecs[4]  = '{8'h37, 8'h00, 16'h0000};
        vecs[5]  = '{8'hFF, 8'h80, 16'h7F80};
        vecs[6]  = '{8'h01, 8'h01, 16'h0001};
        vecs[7]  = '{8'hFF, 8'h01, 16'h00FF};
        vecs[8]  = '{8'h01, 8'hFF, 16'h00FF};
        vecs[9]  = '{8'h10, 8'h10, 16'h0100};
        vecs[10] = '{8'hAA, 8'h55, 16'h3872};

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        mcand     = '0;
        mplier    = '0;
        #12;
        check("reset product", 32'(product), 32'd0);
        check("reset out_valid", 32'(out_valid), 32'd0);
        check("reset busy", 32'(busy), 32'd0);
        check("reset in_ready", 32'(in_ready), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("idle in_ready", 32'(in_ready), 32'd1);
        check("idle busy", 32'(busy), 32'd0);

        for (int i = 0; i < 11; i++) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].p, $sformatf("vec%0d", i));
        end

        // Back-pressure: product held, new operands ignored while DONE.
        mcand     = 8'h21;
        mplier    = 8'h03;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        for (int w = 0; w < 30 && !out_valid; w++) @(negedge clk);
        check("bp out_valid rises", 32'(out_valid), 32'd1);
        for (int c = 0; c < 5; c++) begin
            mcand    = 8'h55;
            mplier   = 8'h55;
            in_valid = (c % 2 == 0);
            check($sformatf("bp product c%0d", c), 32'(product), 32'h0063);
            check($sformatf("bp out_valid c%0d", c), 32'(out_valid), 32'd1);
            check($sformatf("bp in_ready c%0d", c), 32'(in_ready), 32'd0);
            check($sformatf("bp busy c%0d", c), 32'(busy), 32'd1);
            @(negedge clk);
        end
        in_valid  = 1'b0;
        check("bp still valid before accept", 32'(out_valid), 32'd1);
        out_ready = 1'b1;
        @(negedge clk);
        check("bp out_valid dropped", 32'(out_valid), 32'd0);
        check("bp in_ready back", 32'(in_ready), 32'd1);
        run_op(8'h02, 8'h03, 16'h0006, "after bp");

        // Async reset partway through CALC.
        mcand    = 8'h12;
        mplier   = 8'h34;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("midcalc busy", 32'(busy), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async rst product", 32'(product), 32'd0);
        check("async rst out_valid", 32'(out_valid), 32'd0);
        check("async rst busy", 32'(busy), 32'd0);
        check("async rst in_ready", 32'(in_ready), 32'd0);
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (c == 2) rst_n = 1'b1;
            if (out_valid) check("no out_valid after reset", 32'(out_valid), 32'd0);
        end
        run_op(8'h12, 8'h34, 16'h03A8, "post reset");

        // Back-to-back random operations against a reference multiply.
        for (int k = 0; k < 200; k++) begin
            ra = 8'($urandom_range(0, 255));
            rb = 8'($urandom_range(0, 255));
            run_op(ra, rb, 16'(ra) * 16'(rb), $sformatf("rand%0d", k));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mul8_seq.md
Name: mul8_seq

Overview:
Multi-cycle 8x8 unsigned multiplier controller built around one instance of the team's 8-bit ripple adder (fulladd8).
- Sequences the adder through a shift-and-add algorithm, one iteration per clock, producing a 16-bit product.
- Sits beside the ALU as the MUL execution unit.
- Valid/ready handshake on both the operand side and the result side.

Parameters:
ITER, 8, number of shift-add iterations; must equal adder width (only 8 supported)
CNT_W, 4, width of iteration counter; must hold values 0..ITER

Ports:
clk  input  1  system clock, rising-edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  operands present
in_ready  output  1  controller can accept operands (IDLE only)
mcand  input  8  multiplicand
mplier  input  8  multiplier
out_valid  output  1  product valid, held until accepted
out_ready  input  1  consumer accepts product
product  output  16  result {hi, lo}
busy  output  1  high in CALC or DONE

Behaviour:
- One clock. Reset is asynchronous and active-low (rst_n); all flops clear immediately on rst_n low.
- Reset values:
  - state=IDLE, product=0, out_valid=0, busy=0, counter=0.
  - in_ready=0 while rst_n low, then 1 (IDLE).
- Registers: acc[7:0] (high half), mq[7:0] (low half / multiplier shift), mc[7:0] (latched multiplicand), mp[7:0] (unprocessed multiplier bits), cnt[CNT_W-1:0].
- States:
  - IDLE:
    - in_ready=1.
    - On in_valid&&in_ready: mc<=mcand, mq<=mplier, mp<=mplier, acc<=0, cnt<=0 -> CALC.
  - CALC, each cycle:
    - Adder driven with a=acc, b=mc, carry_in=0.
    - If mq[0]=1: {acc,mq} <= {cout, sum, mq[7:1]}; else {acc,mq} <= {1'b0, acc, mq[7:1]}.
    - mp<=mp>>1; cnt<=cnt+1.
    - When cnt==ITER-1 -> DONE.
  - DONE:
    - out_valid=1; product={acc,mq} held stable.
    - On out_valid&&out_ready -> IDLE. out_valid drops and in_ready rises the next cycle.
- Latency: out_valid rises ITER+1 = 9 clocks after the accepting edge.
- No operand accept outside IDLE. in_valid during CALC/DONE is ignored; the operands are not captured.
- Back-pressure: product and out_valid held indefinitely while out_ready=0.
- No pipelining: throughput is one op per ≥10 cycles.
- Arithmetic:
  - Unsigned only.
  - Adder carry_out is the shifted-in MSB, so no overflow is possible: max 0xFF*0xFF=0xFE01.
- Reset mid-CALC or mid-DONE: returns to IDLE, product cleared, partial result discarded, no out_valid pulse.
- product output is driven from {acc,mq} in DONE and is 0 in IDLE/CALC, so no intermediate values are visible.

Optional Feature:
Macro: MUL8_EARLY_TERM_EN.
- Defined: in CALC, if mp==0 before the add step (no remaining 1 bits), go straight to DONE that cycle.
  - {acc,mq} <= {acc,mq} >> (ITER-cnt).
  - Latency becomes (index of highest set multiplier bit + 1) + 1 cycles.
  - mplier=0 gives a 1-cycle CALC and product 0.
- Undefined: fixed 9-cycle latency for all operands; mp register and shifter are not synthesized.

Decomposition:
- Shared package mul8_pkg:
  - State encoding constants ST_IDLE=2'd0, ST_CALC=2'd1, ST_DONE=2'd2.
  - ITER_DEFAULT=8.
  - Product width constant PROD_W=16.
- Sub-module: the existing fulladd8, instantiated once (adder datapath). No other sub-modules.
- FSM, counter and shift registers stay in mul8_seq.

Test Plan:
- mcand=0x0D, mplier=0x0B, out_ready=1 -> product=0x008F, out_valid 9 cycles after accept, single-cycle pulse, in_ready high next cycle.
- mcand=0xFF, mplier=0xFF -> product=0xFE01 (exercises adder carry_out every iteration); mcand=0x00, mplier=0xA5 -> 0x0000.
- out_ready held 0 for 5 cycles after out_valid, in_valid pulsed with new operands meanwhile -> product stable, new operands not captured, in_ready=0 throughout; accept on 6th cycle.
- rst_n low asynchronously at CALC cycle 4 of 0x12*0x34 -> outputs immediately reset values, no out_valid; next op 0x12*0x34 -> 0x03A8.
- Back-to-back random 200 ops vs reference multiply -> all match, latency always 9 (macro undefined).
- MUL8_EARLY_TERM_EN defined: 0x80*0x02 -> 0x0100 after 3 cycles; 0x37*0x00 -> 0x0000 after 2 cycles; 0xFF*0x80 -> 0x7F80 after 9 cycles.
